wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage: MEM/WB pipeline register plus load-data extraction.
- Drives the register file's single write port.
- Also drives a forwarding bus back to decode.
- Guarantees exactly one register-file write per retired instruction, including across stalls, and holds synchronous-RAM load data stable while stalled.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  hold WB register (from pipeline control).
- flush  in  1  replace incoming entry with bubble.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_pc  in  32  PC of MEM instruction.
- mem_we  in  1  instruction writes a register.
- mem_waddr  in  ADDR_W  destination register.
- mem_result  in  DATA_W  ALU/non-load result.
- mem_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 not a load.
- mem_addr_lo  in  2  low address bits of load.
- dmem_rdata  in  DATA_W  data RAM read data, valid in the cycle the load occupies WB.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- wb_valid  out  1  WB holds a live instruction.
- wb_pc  out  32  PC of WB instruction.
- fwd_we  out  1  forwarding valid to decode.
- fwd_waddr  out  ADDR_W  forwarding destination.
- fwd_wdata  out  DATA_W  forwarding data.

Behaviour:
- Reset (resetn=0, async): valid, we, committed and ld_held clear. pc, waddr, result, load_type (set to 7), addr_lo and hold_data all zero. All outputs 0.
- Capture priority per edge: flush > stall > load.
  - flush=1: valid<=0, committed<=0, ld_held<=0, regardless of stall.
  - stall=1, flush=0: all fields hold.
  - Otherwise: load all mem_* fields; committed<=0, ld_held<=0.
- Entry is live when valid=1. wb_valid=valid. wb_pc=pc.
- Load data source: raw = ld_held ? hold_data : dmem_rdata.
- On the first stalled cycle of a live load with ld_held=0: hold_data<=dmem_rdata and ld_held<=1. Subsequent stalled cycles use hold_data. dmem_rdata changes after that are ignored.
- Extraction (combinational from raw, addr_lo):
  - LW: raw; addr_lo ignored.
  - LB/LBU: byte addr_lo, sign- or zero-extended.
  - LH/LHU: halfword addr_lo[1], sign- or zero-extended; addr_lo[0] ignored.
  - Type 5-7: result.
- wdata = extracted value. rf_waddr=waddr. rf_wdata=wdata.
- rf_we = valid & we & (waddr!=0) & ~committed.
- committed<=1 at an edge where rf_we=1 and stall=1. This suppresses repeat writes while held; committed clears on the next load or flush.
- Latency: an instruction captured at edge N is written at edge N+1, i.e. exactly one write per instruction.
- Forwarding:
  - fwd_we = valid & we & (waddr!=0). Stays high while stalled, even after commit.
  - fwd_waddr=waddr. fwd_wdata=wdata.
- Reset mid-stall: entry discarded, no write.
- Flush while stalled with uncommitted entry: that entry's write still occurs in the flush cycle (rf_we evaluated before the edge); bubble thereafter.

Optional Feature:
- Macro WB_DEBUG_TRACE_EN.
- When defined, add outputs debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (ADDR_W) and debug_wb_rf_wdata (DATA_W).
  - debug_wb_pc = pc when rf_we, else 0.
  - debug_wb_rf_wen = {4{rf_we}}.
  - debug_wb_rf_wnum = waddr.
  - debug_wb_rf_wdata = wdata.
  - All outputs are 0 in reset.
- When undefined, these ports and their logic do not exist; other behaviour is identical.

Test Plan:
- Reset: resetn=0 mid-stream with mem_valid=1 -> all outputs 0 immediately; after release, rf_we=0 until the first capture.
- ALU write: mem_we=1, waddr=3, result=0x12345678, type=7 -> the next cycle has rf_we=1, rf_waddr=3, rf_wdata=0x12345678 for exactly one cycle.
- Loads with dmem_rdata=0x8899AABB:
  - LB addr_lo=1 -> 0xFFFFFFAA.
  - LBU addr_lo=3 -> 0x00000088.
  - LH addr_lo=2 -> 0xFFFF8899.
  - LHU addr_lo=0 -> 0x0000AABB.
  - LW -> 0x8899AABB.
- Stall hold: LB to r5 enters WB, stall=1 for 3 cycles, dmem_rdata changes to 0 after the first cycle -> rf_we high only in the first cycle; fwd_wdata stays 0xFFFFFFAA all 3 cycles.
- Zero register: mem_we=1, waddr=0 -> rf_we=0 and fwd_we=0; wb_valid=1.
- Flush priority: stall=1 and flush=1 together -> wb_valid=0 next cycle; no further rf_we.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load extraction, register-file write port and forwarding bus.
// Optional debug trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [31:0]       mem_pc,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic              fwd_we,
  output logic [ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_NONE = 3'd7;

  logic              valid_r;
  logic              we_r;
  logic              committed_r;
  logic              ld_held_r;
  logic [31:0]       pc_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] result_r;
  logic [2:0]        load_type_r;
  logic [1:0]        addr_lo_r;
  logic [DATA_W-1:0] hold_data_r;

  logic              is_load_s;
  logic              wr_target_s;
  logic              rf_we_s;
  logic [DATA_W-1:0] raw_s;
  logic [DATA_W-1:0] wdata_s;

  // Select the addressed byte/halfword of the load word and extend it to DATA_W.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [2:0]        lt,
    input logic [1:0]        lo,
    input logic [DATA_W-1:0] raw,
    input logic [DATA_W-1:0] res
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    case (lo)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      2'd3:    b = raw[31:24];
      default: b = raw[7:0];
    endcase
    h = lo[1] ? raw[31:16] : raw[15:0];
    case (lt)
      LT_LW:   r = raw;
      LT_LB:   r = {{(DATA_W-8){b[7]}}, b};
      LT_LBU:  r = {{(DATA_W-8){1'b0}}, b};
      LT_LH:   r = {{(DATA_W-16){h[15]}}, h};
      LT_LHU:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = res;
    endcase
    return r;
  endfunction

  // Write qualification, load-data source selection and extraction.
  always_comb begin
    is_load_s   = (load_type_r <= LT_LHU);
    wr_target_s = valid_r & we_r & (waddr_r != {ADDR_W{1'b0}});
    rf_we_s     = wr_target_s & ~committed_r;
    if (ld_held_r) begin
      raw_s = hold_data_r;
    end else begin
      raw_s = dmem_rdata;
    end
    wdata_s = extract_load(load_type_r, addr_lo_r, raw_s, result_r);
  end

  // MEM/WB register: flush beats stall beats load; stalled loads latch RAM data once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r     <= 1'b0;
      we_r        <= 1'b0;
      committed_r <= 1'b0;
      ld_held_r   <= 1'b0;
      pc_r        <= 32'd0;
      waddr_r     <= {ADDR_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      load_type_r <= LT_NONE;
      addr_lo_r   <= 2'd0;
      hold_data_r <= {DATA_W{1'b0}};
    end else if (flush) begin
      valid_r     <= 1'b0;
      committed_r <= 1'b0;
      ld_held_r   <= 1'b0;
    end else if (stall) begin
      if (rf_we_s) begin
        committed_r <= 1'b1;
      end
      // The RAM output is only guaranteed during the first WB cycle.
      if (valid_r && is_load_s && !ld_held_r) begin
        hold_data_r <= dmem_rdata;
        ld_held_r   <= 1'b1;
      end
    end else begin
      valid_r     <= mem_valid;
      we_r        <= mem_we;
      pc_r        <= mem_pc;
      waddr_r     <= mem_waddr;
      result_r    <= mem_result;
      load_type_r <= mem_load_type;
      addr_lo_r   <= mem_addr_lo;
      committed_r <= 1'b0;
      ld_held_r   <= 1'b0;
    end
  end

  assign rf_we     = rf_we_s;
  assign rf_waddr  = waddr_r;
  assign rf_wdata  = wdata_s;
  assign wb_valid  = valid_r;
  assign wb_pc     = pc_r;
  assign fwd_we    = wr_target_s;
  assign fwd_waddr = waddr_r;
  assign fwd_wdata = wdata_s;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = rf_we_s ? pc_r : 32'd0;
  assign debug_wb_rf_wen   = {4{rf_we_s}};
  assign debug_wb_rf_wnum  = waddr_r;
  assign debug_wb_rf_wdata = wdata_s;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register-file writes are queued at issue
// and matched by a negedge monitor; directed checks cover stall, flush and reset.
module tb_wb_stage;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_result(mem_result),
    .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
    .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata)
`ifdef WB_DEBUG_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got r%0d=0x%0h expected r%0d=0x%0h", rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] res,
                       input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] pc);
    mem_valid = 1'b1; mem_we = we; mem_waddr = wa; mem_result = res;
    mem_load_type = lt; mem_addr_lo = lo; mem_pc = pc;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_we = 1'b0; mem_waddr = 5'd0; mem_result = 32'd0;
    mem_load_type = 3'd7; mem_addr_lo = 2'd0; mem_pc = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed load vectors: type, addr_lo, destination, expected data.
  logic [2:0]  lv_type [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [1:0]  lv_lo   [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [4:0]  lv_dst  [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  logic [31:0] lv_exp  [5] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};

  initial begin
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'd0;
    idle();
    tick(); tick();
    check("reset_outputs", {31'd0, rf_we, rf_waddr, wb_valid, fwd_we, fwd_waddr}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_rf_we", {63'd0, rf_we}, 64'd0);
    check("post_reset_wb_valid", {63'd0, wb_valid}, 64'd0);

    // ALU write, visible for exactly one cycle.
    issue(1'b1, 5'd3, 32'h12345678, 3'd7, 2'd0, 32'h100);
    expect_wr(5'd3, 32'h12345678);
    tick();
    idle();
    @(negedge clk);
    check("alu_wb_pc", {32'd0, wb_pc}, 64'h100);
    check("alu_fwd", {27'd0, fwd_we, fwd_waddr, fwd_wdata}, {27'd0, 1'b1, 5'd3, 32'h12345678});
    tick();
    @(negedge clk);
    check("alu_one_cycle", {63'd0, rf_we}, 64'd0);

    // Back-to-back loads from a fixed RAM word.
    dmem_rdata = 32'h8899AABB;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, lv_dst[i], 32'hDEADBEEF, lv_type[i], lv_lo[i], 32'h140 + 32'(i * 4));
      expect_wr(lv_dst[i], lv_exp[i]);
      tick();
    end
    idle();
    tick();

    // Zero register is never written or forwarded.
    issue(1'b1, 5'd0, 32'hCAFEF00D, 3'd7, 2'd0, 32'h180);
    tick();
    idle();
    @(negedge clk);
    check("zero_reg_we", {62'd0, rf_we, fwd_we}, 64'd0);
    check("zero_reg_valid", {63'd0, wb_valid}, 64'd1);
    tick();

    // Stall hold: single write, data retained after RAM output changes.
    issue(1'b1, 5'd5, 32'd0, 3'd1, 2'd1, 32'h200);
    expect_wr(5'd5, 32'hFFFFFFAA);
    tick();
    idle();
    stall = 1'b1;
    @(negedge clk);
    check("stall_c1_fwd", {32'd0, fwd_wdata}, 64'hFFFFFFAA);
    for (int c = 2; c <= 3; c++) begin
      tick();
      dmem_rdata = 32'd0;
      @(negedge clk);
      check($sformatf("stall_c%0d_fwd", c), {32'd0, fwd_wdata}, 64'hFFFFFFAA);
      check($sformatf("stall_c%0d_we", c), {62'd0, rf_we, fwd_we}, 64'd1);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    check("stall_release_no_rewrite", {63'd0, rf_we}, 64'd0);
    tick();

    // Flush while stalled: uncommitted write lands, then bubble.
    issue(1'b1, 5'd7, 32'h00000055, 3'd7, 2'd0, 32'h300);
    expect_wr(5'd7, 32'h00000055);
    tick();
    idle();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_bubble", {62'd0, wb_valid, rf_we}, 64'd0);
    tick();

    // Reset mid-stream with a live, writing entry.
    issue(1'b1, 5'd9, 32'h99, 3'd7, 2'd0, 32'h400);
    tick();
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {rf_we, rf_waddr, wb_valid, fwd_we, fwd_waddr, 21'd0}, 64'd0);
    check("async_reset_data", {rf_wdata, wb_pc}, 64'd0);
    tick();
    check("reset_held_fwd", {32'd0, fwd_wdata}, 64'd0);
    idle();
    resetn = 1'b1;
    @(negedge clk);
    check("reset_release_rf_we", {63'd0, rf_we}, 64'd0);
    tick(); tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
